// File: rtl/serial_pattern_tx_pkg.sv
// Shared types for the serial pattern transmitter and the zero detector bench.
package serial_pattern_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } tx_state_t;

  // Width needed to hold a zero count from 0 up to and including w.
  function automatic int zc_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/serial_pattern_tx_zero_popcount.sv
// Combinational count of 0 bits across a word.
module zero_popcount
  import serial_pattern_tx_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int ZW = zc_width(WIDTH)
) (
  input  logic [WIDTH-1:0] data,
  output logic [ZW-1:0]    zeros
);

  // Ripple count of cleared bits; WIDTH is small so a linear sum is fine.
  always_comb begin
    zeros = '0;
    for (int i = 0; i < WIDTH; i++)
      if (!data[i]) zeros = zeros + ZW'(1);
  end

endmodule

// File: rtl/serial_pattern_tx.sv
// MSB-first serial transmitter with valid/ready word input and an idle gap
// between words. Every output is a register.
module serial_pattern_tx
  import serial_pattern_tx_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int GAP_CYCLES = 2,
  parameter bit IDLE_LEVEL = 1'b1,
  localparam int ZW = zc_width(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic             x_out,
  output logic             bit_valid,
  output logic             word_done,
  output logic [ZW-1:0]    zero_count
);

  localparam int              CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST     = CW'(WIDTH - 1);
  localparam logic [CW-1:0]   PRE_LAST = CW'(WIDTH - 2);
  localparam logic [3:0]      GAP_LOAD = 4'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  tx_state_t        state, state_n;
  logic [WIDTH-1:0] sh, sh_n;         // bits still to send, next one at MSB
  logic [CW-1:0]    bit_cnt, bit_cnt_n;
  logic [3:0]       gap_cnt, gap_cnt_n;
  logic             x_n, bv_n, wd_n, rdy_n;
  logic [ZW-1:0]    zc_n, zc_load;
  logic             acc, do_load;

  assign acc = valid_in & ready_out;

  zero_popcount #(.WIDTH(WIDTH)) u_zpc (
    .data  (data_in),
    .zeros (zc_load)
  );

  // State and registered outputs; reset abandons any word in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      sh         <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      x_out      <= IDLE_LEVEL;
      bit_valid  <= 1'b0;
      word_done  <= 1'b0;
      ready_out  <= 1'b1;
      zero_count <= '0;
    end else begin
      state      <= state_n;
      sh         <= sh_n;
      bit_cnt    <= bit_cnt_n;
      gap_cnt    <= gap_cnt_n;
      x_out      <= x_n;
      bit_valid  <= bv_n;
      word_done  <= wd_n;
      ready_out  <= rdy_n;
      zero_count <= zc_n;
    end
  end

  // Next-state and next-output values, computed one cycle ahead.
  always_comb begin
    state_n   = state;
    sh_n      = sh;
    bit_cnt_n = bit_cnt;
    gap_cnt_n = gap_cnt;
    x_n       = IDLE_LEVEL;
    bv_n      = 1'b0;
    wd_n      = 1'b0;
    rdy_n     = 1'b0;
    zc_n      = zero_count;
    do_load   = 1'b0;

    case (state)
      IDLE: begin
        rdy_n = 1'b1;
        if (acc) do_load = 1'b1;
      end
      SHIFT: begin
        if (bit_cnt != LAST) begin
          x_n       = sh[WIDTH-1];
          sh_n      = sh << 1;
          bit_cnt_n = bit_cnt + CW'(1);
          bv_n      = 1'b1;
          wd_n      = (bit_cnt == PRE_LAST);
          // With no gap the line can take a new word during its last bit.
          rdy_n     = (bit_cnt == PRE_LAST) && (GAP_CYCLES == 0);
        end else if (GAP_CYCLES > 0) begin
          state_n   = GAP;
          gap_cnt_n = GAP_LOAD;
        end else if (acc) begin
          do_load = 1'b1;
        end else begin
          state_n = IDLE;
          rdy_n   = 1'b1;
        end
      end
      GAP: begin
        if (gap_cnt == 4'd0) begin
          state_n = IDLE;
          rdy_n   = 1'b1;
        end else begin
          gap_cnt_n = gap_cnt - 4'd1;
        end
      end
      default: begin
        state_n = IDLE;
        rdy_n   = 1'b1;
      end
    endcase

    // Word load: MSB goes straight to the line, the rest waits in sh.
    if (do_load) begin
      state_n   = SHIFT;
      x_n       = data_in[WIDTH-1];
      sh_n      = data_in << 1;
      bit_cnt_n = '0;
      bv_n      = 1'b1;
      wd_n      = 1'b0;
      rdy_n     = 1'b0;
      zc_n      = zc_load;
    end
  end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed bench: one instance with a 2-cycle gap, one with no gap.
module tb_serial_pattern_tx;

  logic       clock;
  logic       reset_a, valid_a, reset_b, valid_b;
  logic [7:0] data_a, data_b;
  logic       rdy_a, x_a, bv_a, wd_a;
  logic       rdy_b, x_b, bv_b, wd_b;
  logic [3:0] zc_a, zc_b;
  int         n_chk, n_err;

  serial_pattern_tx #(.WIDTH(8), .GAP_CYCLES(2), .IDLE_LEVEL(1'b1)) u_g2 (
    .clock(clock), .reset(reset_a), .data_in(data_a), .valid_in(valid_a),
    .ready_out(rdy_a), .x_out(x_a), .bit_valid(bv_a), .word_done(wd_a),
    .zero_count(zc_a)
  );

  serial_pattern_tx #(.WIDTH(8), .GAP_CYCLES(0), .IDLE_LEVEL(1'b1)) u_g0 (
    .clock(clock), .reset(reset_b), .data_in(data_b), .valid_in(valid_b),
    .ready_out(rdy_b), .x_out(x_b), .bit_valid(bv_b), .word_done(wd_b),
    .zero_count(zc_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs are driven and outputs sampled on the falling edge.
  task automatic tick();
    @(negedge clock);
  endtask

  task automatic chk_idle_a(input string tag, input logic rdy, input logic [3:0] zc);
    chk({tag, ".x"},   32'(x_a),   32'd1);
    chk({tag, ".bv"},  32'(bv_a),  32'd0);
    chk({tag, ".wd"},  32'(wd_a),  32'd0);
    chk({tag, ".rdy"}, 32'(rdy_a), 32'(rdy));
    chk({tag, ".zc"},  32'(zc_a),  32'(zc));
  endtask

  task automatic do_abort_a();
    reset_a = 1'b1;
    tick();
    chk_idle_a("abort", 1'b1, 4'd0);
    reset_a = 1'b0;
  endtask

  // Checks a word on u_g2 from its first bit onward. abort_at 0..7 resets
  // after that bit, 8 resets in the first gap cycle, -1 runs to completion.
  task automatic run_word_a(input logic [7:0] d, input logic [3:0] zc,
                            input bit inj, input int abort_at);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick();
      chk("bit.x",   32'(x_a),   32'(d[7-i]));
      chk("bit.bv",  32'(bv_a),  32'd1);
      chk("bit.wd",  32'(wd_a),  32'(i == 7));
      chk("bit.rdy", 32'(rdy_a), 32'd0);
      chk("bit.zc",  32'(zc_a),  32'(zc));
      if (inj && i == 2) begin valid_a = 1'b1; data_a = 8'h55; end
      if (inj && i == 5) valid_a = 1'b0;
      if (abort_at == i) begin do_abort_a(); return; end
    end
    tick(); chk_idle_a("gap0", 1'b0, zc);
    if (abort_at == 8) begin do_abort_a(); return; end
    tick(); chk_idle_a("gap1", 1'b0, zc);
    tick(); chk_idle_a("rdy",  1'b1, zc);
  endtask

  task automatic send_a(input logic [7:0] d, input logic [3:0] zc, input bit inj, input int abort_at);
    data_a = d; valid_a = 1'b1;
    tick();
    valid_a = 1'b0;
    run_word_a(d, zc, inj, abort_at);
  endtask

  initial begin
    logic [15:0] s;
    n_chk = 0; n_err = 0;
    reset_a = 1'b1; reset_b = 1'b1;
    valid_a = 1'b0; valid_b = 1'b0;
    data_a = 8'h00; data_b = 8'h00;
    tick(); tick();
    reset_a = 1'b0; reset_b = 1'b0;

    // Reset and idle on both instances.
    for (int i = 0; i < 4; i++) begin
      chk_idle_a("rst_a", 1'b1, 4'd0);
      chk("rst_b.x",   32'(x_b),   32'd1);
      chk("rst_b.bv",  32'(bv_b),  32'd0);
      chk("rst_b.rdy", 32'(rdy_b), 32'd1);
      chk("rst_b.zc",  32'(zc_b),  32'd0);
      tick();
    end

    // Single word, then extreme words.
    send_a(8'hB2, 4'd4, 1'b0, -1);
    send_a(8'h00, 4'd8, 1'b0, -1);
    send_a(8'hFF, 4'd0, 1'b0, -1);

    // Reset after three bits: no word_done, line idles, then a clean word.
    send_a(8'hA5, 4'd4, 1'b0, 2);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_idle_a("post_abort", 1'b1, 4'd0);
    end
    send_a(8'h3C, 4'd4, 1'b0, -1);

    // valid_in during the releasing reset edge is ignored, taken next edge.
    reset_a = 1'b1; valid_a = 1'b1; data_a = 8'h81;
    tick();
    chk_idle_a("rst_valid", 1'b1, 4'd0);
    reset_a = 1'b0;
    tick();
    valid_a = 1'b0;
    // Reset in the gap: back to idle, next word accepted at once.
    run_word_a(8'h81, 4'd6, 1'b0, 8);
    data_a = 8'hFF; valid_a = 1'b1;
    tick();
    valid_a = 1'b0;
    run_word_a(8'hFF, 4'd0, 1'b0, -1);

    // valid_in with 8'h55 while shifting 8'hC3 is dropped.
    send_a(8'hC3, 4'd4, 1'b1, -1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_idle_a("no55", 1'b1, 4'd4);
    end

    // No-gap instance: F0 then 0F with valid held, no bubble.
    s = 16'hF00F;
    data_b = 8'hF0; valid_b = 1'b1;
    tick();
    data_b = 8'h0F;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) tick();
      chk("b2b.x",   32'(x_b),   32'(s[15-i]));
      chk("b2b.bv",  32'(bv_b),  32'd1);
      chk("b2b.wd",  32'(wd_b),  32'(i == 7 || i == 15));
      chk("b2b.rdy", 32'(rdy_b), 32'(i == 7 || i == 15));
      chk("b2b.zc",  32'(zc_b),  32'd4);
      if (i == 8) valid_b = 1'b0;
    end
    tick();
    chk("b2b_end.x",   32'(x_b),   32'd1);
    chk("b2b_end.bv",  32'(bv_b),  32'd0);
    chk("b2b_end.wd",  32'(wd_b),  32'd0);
    chk("b2b_end.rdy", 32'(rdy_b), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
